// File: rtl/prbs8_pkg.sv
// Shared definitions for the x^8+x^6+x^5+x^4+1 PRBS checker/generator pair.
package prbs8_pkg;

  localparam int LFSR_W = 8;

  // Feedback taps on the reference register, hist[0] being the newest bit.
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  localparam int DEF_LOCK_CNT   = 8;
  localparam int DEF_WINDOW     = 64;
  localparam int DEF_ERR_THRESH = 4;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/prbs8_checker_if.sv
// Serial PRBS receive bundle: bit stream in, lock status and error statistics out.
interface prbs8_checker_if import prbs8_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);

  logic              din;
  logic              din_valid;
  logic              clear;
  logic              locked;
  logic              err;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LFSR_W-1:0] data;

  modport master (
    output din, din_valid, clear,
    input  locked, err, err_cnt, bit_cnt, data
  );

  modport slave (
    input  din, din_valid, clear,
    output locked, err, err_cnt, bit_cnt, data
  );

endinterface

// File: rtl/prbs8_step.sv
// Next-bit prediction of the PRBS8 recurrence from the last eight bits.
module prbs8_step import prbs8_pkg::*; (
  input  logic [LFSR_W-1:0] hist,
  output logic              p
);

  assign p = hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C] ^ hist[TAP_D];

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 checker: hunts, verifies, then free-runs a local
// reference and counts bit errors, dropping lock on excessive error density.
module prbs8_checker import prbs8_pkg::*; #(
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  prbs8_checker_if.slave bus
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WP_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W   = $clog2(ERR_THRESH + 1);
  localparam int FILL_W = $clog2(LFSR_W);

  state_t            state_reg;
  logic [LFSR_W-1:0] hist_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [RUN_W-1:0]  run_reg;
  logic [WP_W-1:0]   win_pos_reg;
  logic [WE_W-1:0]   win_err_reg;
  logic              locked_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  err_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;

  logic              p;
  logic              mism;
  logic              win_wrap;
  logic [WE_W-1:0]   win_sum;

  prbs8_step u_step (
    .hist (hist_reg),
    .p    (p)
  );

  assign mism     = bus.din ^ p;
  assign win_wrap = (win_pos_reg == WP_W'(WINDOW - 1));
  // win_err never exceeds ERR_THRESH-1 while locked, so this cannot overflow.
  assign win_sum  = win_err_reg + WE_W'(mism);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= HUNT;
      hist_reg    <= '0;
      fill_reg    <= '0;
      run_reg     <= '0;
      win_pos_reg <= '0;
      win_err_reg <= '0;
      locked_reg  <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      if (bus.din_valid) begin
        unique case (state_reg)
          HUNT: begin
            hist_reg <= {hist_reg[LFSR_W-2:0], bus.din};
            if (fill_reg == FILL_W'(LFSR_W - 1)) begin
              fill_reg  <= '0;
              run_reg   <= '0;
              state_reg <= VERIFY;
            end else begin
              fill_reg <= fill_reg + 1'b1;
            end
          end
          VERIFY: begin
            hist_reg <= {hist_reg[LFSR_W-2:0], bus.din};
            // An all-zero register predicts zero forever, so it never counts.
            if (!mism && (hist_reg != '0)) begin
              if (run_reg == RUN_W'(LOCK_CNT - 1)) begin
                run_reg     <= '0;
                win_pos_reg <= '0;
                win_err_reg <= '0;
                locked_reg  <= 1'b1;
                state_reg   <= LOCKED;
              end else begin
                run_reg <= run_reg + 1'b1;
              end
            end else begin
              run_reg <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so one flipped bit costs one error.
            hist_reg <= {hist_reg[LFSR_W-2:0], p};
            if (bit_cnt_reg != '1) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (mism) begin
              err_reg <= 1'b1;
              if (err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
              end
            end
            win_pos_reg <= win_wrap ? '0 : win_pos_reg + 1'b1;
            if (win_sum >= WE_W'(ERR_THRESH)) begin
              win_err_reg <= '0;
              fill_reg    <= '0;
              locked_reg  <= 1'b0;
              state_reg   <= HUNT;
            end else begin
              win_err_reg <= win_wrap ? '0 : win_sum;
            end
          end
          default: begin
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
          end
        endcase
      end
      // Placed last so a same-cycle clear overrides any increment above.
      if (bus.clear) begin
        err_cnt_reg <= '0;
        bit_cnt_reg <= '0;
      end
    end
  end

  assign bus.locked  = locked_reg;
  assign bus.err     = err_reg;
  assign bus.err_cnt = err_cnt_reg;
  assign bus.bit_cnt = bit_cnt_reg;
  assign bus.data    = hist_reg;

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench: two checker instances (default and narrow-counter) share one
// stimulus stream and are compared cycle by cycle against a sequence-level model.
module tb_prbs8_checker;

  localparam int CW_A  = 16;
  localparam int CW_B  = 4;
  localparam int TH_A  = 4;
  localparam int TH_B  = 255;
  localparam int LOCK  = 8;
  localparam int WIN   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din, din_valid, clear;

  prbs8_checker_if #(.CNT_W(CW_A)) bus_a ();
  prbs8_checker_if #(.CNT_W(CW_B)) bus_b ();

  assign bus_a.din       = din;
  assign bus_a.din_valid = din_valid;
  assign bus_a.clear     = clear;
  assign bus_b.din       = din;
  assign bus_b.din_valid = din_valid;
  assign bus_b.clear     = clear;

  prbs8_checker #(.LOCK_CNT(LOCK), .WINDOW(WIN), .ERR_THRESH(TH_A), .CNT_W(CW_A)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  prbs8_checker #(.LOCK_CNT(LOCK), .WINDOW(WIN), .ERR_THRESH(TH_B), .CNT_W(CW_B)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Model: w[i] holds bit b[n-8+i] of the stream (w[7] newest); the PRBS rule is
  // b[n] = b[n-8]^b[n-6]^b[n-5]^b[n-4].
  typedef struct {
    int         mode;   // 0 hunt, 1 verify, 2 locked
    int         fill;
    int         run;
    int         k;
    int         win;
    int         errc;
    int         bitc;
    int         cmax;
    int         thresh;
    logic [7:0] w;
    bit         errp;
  } model_t;

  typedef struct {
    bit         v;
    bit         din;
    bit         lk_a, er_a, lk_b, er_b;
    int         ec_a, bc_a, ec_b, bc_b;
    logic [7:0] d_a, d_b;
  } exp_t;

  model_t ma, mb;
  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     txn = 0;
  logic [7:0] gw;
  int     gidx;
  logic [7:0] seed_v = 8'h01;

  function automatic model_t m_reset(model_t m);
    m.mode = 0; m.fill = 0; m.run = 0; m.k = 0; m.win = 0;
    m.errc = 0; m.bitc = 0; m.w = '0; m.errp = 1'b0;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, bit v, bit d, bit c);
    bit pred;
    bit nz;
    m.errp = 1'b0;
    if (v) begin
      pred = m.w[0] ^ m.w[2] ^ m.w[3] ^ m.w[4];
      nz   = (m.w != 8'h00);
      case (m.mode)
        0: begin
          m.w = {d, m.w[7:1]};
          m.fill++;
          if (m.fill == 8) begin m.mode = 1; m.run = 0; end
        end
        1: begin
          m.w = {d, m.w[7:1]};
          if (d == pred && nz) begin
            m.run++;
            if (m.run == LOCK) begin m.mode = 2; m.k = 0; m.win = 0; end
          end else begin
            m.run = 0;
          end
        end
        default: begin
          m.w = {pred, m.w[7:1]};
          if (m.k % WIN == 0) m.win = 0;
          if (m.bitc < m.cmax) m.bitc++;
          if (d != pred) begin
            m.errp = 1'b1;
            if (m.errc < m.cmax) m.errc++;
            m.win++;
          end
          m.k++;
          if (m.win >= m.thresh) begin m.mode = 0; m.fill = 0; end
        end
      endcase
    end
    if (c) begin m.errc = 0; m.bitc = 0; end
    return m;
  endfunction

  function automatic logic [7:0] rev8(logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic gen_reset();
    gw = '0;
    gidx = 0;
  endtask

  task automatic gen_bit(output bit b);
    if (gidx < 8) b = seed_v[7-gidx];
    else          b = gw[0] ^ gw[2] ^ gw[3] ^ gw[4];
    gw = {b, gw[7:1]};
    gidx++;
  endtask

  task automatic drive(bit v, bit d, bit c, bit r);
    exp_t e;
    @(negedge clk);
    din_valid = v; din = d; clear = c; rst = r;
    if (!r) begin
      ma = m_reset(ma);
      mb = m_reset(mb);
    end else begin
      ma = m_step(ma, v, d, c);
      mb = m_step(mb, v, d, c);
    end
    e.v = v; e.din = d;
    e.lk_a = (ma.mode == 2); e.er_a = ma.errp; e.ec_a = ma.errc; e.bc_a = ma.bitc; e.d_a = rev8(ma.w);
    e.lk_b = (mb.mode == 2); e.er_b = mb.errp; e.ec_b = mb.errc; e.bc_b = mb.bitc; e.d_b = rev8(mb.w);
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic clean(int n);
    bit b;
    repeat (n) begin gen_bit(b); drive(1'b1, b, 1'b0, 1'b1); end
  endtask

  task automatic flipped();
    bit b;
    gen_bit(b);
    drive(1'b1, ~b, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    gen_reset();
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked_a",  bus_a.locked,  e.lk_a);
        chk("err_a",     bus_a.err,     e.er_a);
        chk("err_cnt_a", bus_a.err_cnt, e.ec_a);
        chk("bit_cnt_a", bus_a.bit_cnt, e.bc_a);
        chk("data_a",    bus_a.data,    e.d_a);
        chk("locked_b",  bus_b.locked,  e.lk_b);
        chk("err_b",     bus_b.err,     e.er_b);
        chk("err_cnt_b", bus_b.err_cnt, e.ec_b);
        chk("bit_cnt_b", bus_b.bit_cnt, e.bc_b);
        chk("data_b",    bus_b.data,    e.d_b);
        if (e.v) begin
          txn++;
          $display("txn %0d din=%0b lock_a=%0b err_a=%0b ec_a=%0d bc_a=%0d lock_b=%0b ec_b=%0d",
                   txn, e.din, bus_a.locked, bus_a.err, bus_a.err_cnt, bus_a.bit_cnt,
                   bus_b.locked, bus_b.err_cnt);
        end
      end
    end
  end

  initial begin
    bit b, v, c, r, ever;
    int vc;
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    ma.cmax = (1 << CW_A) - 1; ma.thresh = TH_A;
    mb.cmax = (1 << CW_B) - 1; mb.thresh = TH_B;
    ma = m_reset(ma);
    mb = m_reset(mb);
    gen_reset();

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_locked",  bus_a.locked,  0);
    chk("rst_err",     bus_a.err,     0);
    chk("rst_err_cnt", bus_a.err_cnt, 0);
    chk("rst_bit_cnt", bus_a.bit_cnt, 0);
    chk("rst_data",    bus_a.data,    0);

    // Clean stream: lock after valid bit 16, then 1000 error-free bits.
    clean(15); settle(); chk("lock_bit15", bus_a.locked, 0);
    clean(1);  settle(); chk("lock_bit16", bus_a.locked, 1);
    chk("lock_bit16_b", bus_b.locked, 1);
    clean(1000); settle();
    chk("clean_err_cnt", bus_a.err_cnt, 0);
    chk("clean_bit_cnt", bus_a.bit_cnt, 1000);
    chk("sat_bit_cnt_b", bus_b.bit_cnt, 15);

    // Single flipped bit.
    clean(10); flipped(); settle();
    chk("flip1_err_pulse", bus_a.err, 1);
    clean(60); settle();
    chk("flip1_err_cnt", bus_a.err_cnt, 1);
    chk("flip1_locked",  bus_a.locked,  1);

    // Reset mid-lock, then relock.
    drive(1'b1, 1'b0, 1'b0, 1'b0); settle();
    chk("midrst_locked",  bus_a.locked,  0);
    chk("midrst_err_cnt", bus_a.err_cnt, 0);
    chk("midrst_bit_cnt", bus_a.bit_cnt, 0);
    chk("midrst_data",    bus_a.data,    0);
    clean(16); settle(); chk("relock_after_rst", bus_a.locked, 1);

    // Four flips inside the first window after lock force loss of lock.
    for (int f = 0; f < 4; f++) begin
      clean($urandom_range(3, 12));
      flipped();
      settle();
      if (f == 2) chk("flip3_still_locked", bus_a.locked, 1);
    end
    chk("flip4_unlocked", bus_a.locked,  0);
    chk("flip4_err_cnt",  bus_a.err_cnt, 4);
    chk("flip4_b_locked", bus_b.locked,  1);
    clean(15); settle(); chk("relock_bit15", bus_a.locked, 0);
    clean(1);  settle(); chk("relock_bit16", bus_a.locked, 1);

    // Clear while locked.
    gen_bit(b); drive(1'b1, b, 1'b1, 1'b1); settle();
    chk("clear_err_cnt", bus_a.err_cnt, 0);
    chk("clear_bit_cnt", bus_a.bit_cnt, 0);
    chk("clear_locked",  bus_a.locked,  1);

    // Narrow counter saturation with a threshold that never trips.
    repeat (20) begin clean(4); flipped(); end
    settle();
    chk("sat_err_cnt_b", bus_b.err_cnt, 15);
    chk("sat_locked_b",  bus_b.locked,  1);

    // Valid on every third cycle: lock point in valid bits is unchanged.
    do_reset();
    vc = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 2) begin
        gen_bit(b);
        drive(1'b1, b, 1'b0, 1'b1);
        vc++;
        if (vc == 15) begin settle(); chk("sparse_bit15", bus_a.locked, 0); end
        if (vc == 16) begin settle(); chk("sparse_bit16", bus_a.locked, 1); end
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
    end

    // All-zero stream never locks.
    do_reset();
    ever = 1'b0;
    repeat (500) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      if (bus_a.locked) ever = 1'b1;
    end
    chk("zero_never_locks", ever, 0);

    // Stream joined three bits in.
    do_reset();
    repeat (3) gen_bit(b);
    clean(15); settle(); chk("shift_bit15", bus_a.locked, 0);
    clean(1);  settle(); chk("shift_bit16", bus_a.locked, 1);

    // Randomised traffic: gaps, sparse bit errors, occasional clear and reset.
    repeat (2500) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) begin
        gen_bit(b);
        if ($urandom_range(0, 59) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 999) != 0);
      drive(v, b, c, r);
    end

    repeat (3) settle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
